// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer blocks (write and read side).
// The conversion functions work on a 32-bit vector. Callers zero-extend their
// pointer into it and truncate the result back to pointer width. For a
// zero-extended input, the unused upper bits never affect the low bits.
package async_fifo_pkg;

  localparam int unsigned CONV_W = 32;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
    logic [CONV_W-1:0] bin;
    bin[CONV_W-1] = gray[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_wptr_full.sv
// Write-side pointer and flag generator for the dual-clock FIFO.
// Owns the binary and gray write pointers. Publishes the gray pointer to the
// read domain. Derives full, almost_full, level and a sticky overflow flag by
// comparing against the read pointer that has already been synchronized into clk.
// The flags are pessimistic: space freed by a read shows up here only once
// rptr_sync has advanced.
module async_fifo_wptr_full
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_sync,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AFULL_L = PTR_W'(AFULL_LEVEL);

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] full_match;

  // The write strobe is the only combinational output. It is gated by the registered full.
  assign wr_accept = wr_en & ~full;
  assign waddr     = wbin[ADDR_WIDTH-1:0];

  // Next-state pointers and level. Arithmetic wraps modulo 2**PTR_W.
  always_comb begin
    wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wr_accept};
    wgray_next = PTR_W'(bin2gray(CONV_W'(wbin_next)));
    rbin       = PTR_W'(gray2bin(CONV_W'(rptr_sync)));
    level_next = wbin_next - rbin;
    // The FIFO is full when the gray pointers differ only in their top two bits (one lap ahead).
    full_match = {~rptr_sync[PTR_W-1:PTR_W-2], rptr_sync[PTR_W-3:0]};
  end

  // Pointer registers. wptr moves by one bit per accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin <= '0;
      wptr <= '0;
    end else begin
      wbin <= wbin_next;
      wptr <= wgray_next;
    end
  end

  // Registered flags and level. All of them come from the same next-state level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
    end else begin
      full        <= (wgray_next == full_match);
      almost_full <= (level_next >= AFULL_L);
      wr_level    <= level_next;
    end
  end

  // Sticky overflow flag. It sets on any write attempt while full and clears only on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Bench for async_fifo_wptr_full. It keeps a count-based model: the total
// accepted writes and the read count give level, full and almost_full as plain
// arithmetic. Directed literal checks pin the model's numbers.
module tb_async_fifo_wptr_full;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW:0]   rptr_sync;
  logic          wr_accept;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  // stimulus-side read count (unbounded) and model state
  int  r_cnt = 0;
  int  m_w   = 0;
  int  m_r   = 0;
  bit  m_ovf = 0;
  bit  chk_en = 0;

  async_fifo_wptr_full #(.ADDR_WIDTH(AW), .AFULL_LEVEL(AFL)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rptr_sync(rptr_sync),
    .wr_accept(wr_accept), .waddr(waddr), .wptr(wptr), .full(full),
    .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int gray_of(input int v);
    int m;
    m = v & 31;
    return m ^ (m >> 1);
  endfunction

  function automatic int m_level();
    return (m_w - m_r) & 31;
  endfunction

  function automatic bit m_full();
    return m_level() == DEPTH;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: count writes accepted, remember the read count seen
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_w   <= 0;
      m_r   <= 0;
      m_ovf <= 0;
    end else begin
      if (wr_en && !m_full()) m_w <= m_w + 1;
      if (wr_en && m_full()) m_ovf <= 1;
      m_r <= r_cnt;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_wr_accept", int'(wr_accept), int'(wr_en && !m_full()));
      chk("cmp_waddr", int'(waddr), m_w & 15);
      chk("cmp_wptr", int'(wptr), gray_of(m_w));
      chk("cmp_full", int'(full), int'(m_full()));
      chk("cmp_afull", int'(almost_full), int'(m_level() >= AFL));
      chk("cmp_level", int'(wr_level), m_level());
      chk("cmp_overflow", int'(overflow), int'(m_ovf));
    end
  end

  // Inputs are driven 2 time units after a posedge, and the DUT samples them at the next posedge.
  task automatic cyc(input bit we, input int r);
    wr_en     = we;
    r_cnt     = r;
    rptr_sync = 5'(gray_of(r));
    @(posedge clk);
    #2;
  endtask

  int gtab[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 24};

  initial begin
    int lvl;
    int adv;
    wr_en = 1;
    rptr_sync = 0;
    rst_n = 0;
    // reset with wr_en high
    repeat (3) @(posedge clk);
    #2;
    chk("rst_wr_accept", int'(wr_accept), 1);
    chk("rst_wptr", int'(wptr), 0);
    wr_en = 0;
    rst_n = 1;
    #1;
    chk("rel_wptr", int'(wptr), 0);
    chk("rel_waddr", int'(waddr), 0);
    chk("rel_full", int'(full), 0);
    chk("rel_level", int'(wr_level), 0);
    chk("rel_overflow", int'(overflow), 0);
    @(posedge clk);
    #2;
    chk_en = 1;

    // fill 16 with rptr_sync at 0
    for (int k = 1; k <= 16; k++) begin
      wr_en = 1;
      #1;
      chk("fill_waddr", int'(waddr), k - 1);
      #1;
      cyc(1, 0);
      chk("fill_wptr", int'(wptr), gtab[k]);
      chk("fill_afull", int'(almost_full), int'(k >= 14));
      chk("fill_full", int'(full), int'(k == 16));
    end
    chk("full_level", int'(wr_level), 16);
    chk("full_wptr", int'(wptr), 24);

    // overflow
    wr_en = 1;
    #1;
    chk("ovf_wr_accept", int'(wr_accept), 0);
    @(posedge clk);
    #2;
    chk("ovf_wptr", int'(wptr), 24);
    chk("ovf_set", int'(overflow), 1);

    // drain response
    cyc(0, 1);
    chk("drain_full", int'(full), 0);
    chk("drain_level", int'(wr_level), 15);
    chk("drain_ovf_sticky", int'(overflow), 1);
    cyc(1, 1);
    chk("refill_full", int'(full), 1);

    // bring the level down to 2, then write 40 times with the read count trailing by 2
    for (int r = 2; r <= 15; r++) cyc(0, r);
    chk("pre_wrap_level", int'(wr_level), 2);
    for (int k = 0; k < 40; k++) begin
      cyc(1, r_cnt + 1);
      chk("wrap_level", int'(wr_level), 2);
      chk("wrap_full", int'(full), 0);
      if ((m_w & 31) == 0) chk("wrap_wptr_zero", int'(wptr), 0);
    end

    // reach level 8, then write while the read count advances by one
    for (int k = 0; k < 6; k++) cyc(1, r_cnt);
    chk("sim_pre_level", int'(wr_level), 8);
    cyc(1, r_cnt + 1);
    chk("sim_level", int'(wr_level), 8);
    chk("sim_afull", int'(almost_full), 0);

    // randomized phases with varying write pressure
    for (int k = 0; k < 3000; k++) begin
      bit we;
      int wp;
      wp  = ((k / 200) % 3 == 0) ? 90 : (((k / 200) % 3 == 1) ? 50 : 20);
      we  = ($urandom_range(0, 99) < wp);
      lvl = m_w - r_cnt;
      adv = (lvl > 0) ? $urandom_range(0, (lvl < 2) ? lvl : 2) : 0;
      if ($urandom_range(0, 3) == 0) adv = 0;
      cyc(we, r_cnt + adv);
    end

    // asynchronous reset between edges
    @(posedge clk);
    #4;
    chk_en = 0;
    wr_en = 0;
    r_cnt = 0;
    rptr_sync = 0;
    rst_n = 0;
    #1;
    chk("arst_wptr", int'(wptr), 0);
    chk("arst_waddr", int'(waddr), 0);
    chk("arst_full", int'(full), 0);
    chk("arst_afull", int'(almost_full), 0);
    chk("arst_level", int'(wr_level), 0);
    chk("arst_overflow", int'(overflow), 0);
    @(posedge clk);
    #2;
    rst_n = 1;
    @(posedge clk);
    #2;
    chk_en = 1;
    for (int k = 0; k < 200; k++) begin
      lvl = m_w - r_cnt;
      adv = (lvl > 0 && $urandom_range(0, 2) == 0) ? 1 : 0;
      cyc($urandom_range(0, 1) == 1, r_cnt + adv);
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/async_fifo_wptr_full.md
Name: async_fifo_wptr_full

Overview:
Write-domain pointer and flag generator for the dual-clock FIFO. It owns the binary and gray write pointers and produces the memory write address and write strobe. It publishes the gray write pointer to the read-domain pointer synchronizer. It compares its own pointer against the read pointer that has been synchronized into this clock domain, and from that derives full, almost_full, fill level and a sticky overflow flag.

Parameters:
ADDR_WIDTH, 4, address bits; FIFO depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AFULL_LEVEL, 14, almost_full asserts when level >= AFULL_LEVEL; legal range 1..DEPTH.

Ports:
clk  input  1  write-domain clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request from producer
rptr_sync  input  ADDR_WIDTH+1  gray read pointer, already 2-flop synchronized into clk
wr_accept  output  1  memory write strobe; wr_en & ~full
waddr  output  ADDR_WIDTH  memory write address; wbin[ADDR_WIDTH-1:0]
wptr  output  ADDR_WIDTH+1  registered gray write pointer, to read-domain synchronizer
full  output  1  FIFO full, registered
almost_full  output  1  level >= AFULL_LEVEL, registered
wr_level  output  ADDR_WIDTH+1  write-side fill count 0..DEPTH, registered
overflow  output  1  sticky: set on any wr_en while full

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low: clk and rst_n.
- Reset values: wbin=0, wptr=0, full=0, almost_full=0, wr_level=0, overflow=0. Therefore waddr=0 and wr_accept=wr_en.
- Reset asserted mid-operation clears all state immediately, regardless of clk.
- wr_accept is combinational from wr_en and the registered full. No other output is combinational.
- wbin_next = wbin + wr_accept, modulo 2**(ADDR_WIDTH+1). It wraps naturally; after 2*DEPTH accepted writes it returns to 0.
- wgray_next = wbin_next ^ (wbin_next >> 1).
- wbin and wptr are registered from these next values. wptr changes by exactly one bit per accepted write, which keeps it glitch-safe for the synchronizer.
- full register <= (wgray_next == {~rptr_sync[MSB:MSB-1], rptr_sync[MSB-2:0]}).
- rbin = gray2bin(rptr_sync).
- wr_level register <= (wbin_next - rbin), modulo 2**(ADDR_WIDTH+1). The result is never above DEPTH for legal pointers.
- almost_full register <= (wbin_next - rbin) >= AFULL_LEVEL. It uses the same next-state level as wr_level, so almost_full and wr_level agree every cycle.
- Latency: an accepted write on edge N is visible in wptr, wr_level, full and almost_full after edge N.
- A change in rptr_sync is reflected in full, almost_full and wr_level one clk edge later.
- Full boundary: wr_en while full -> wr_accept=0, pointers hold, overflow sets at the next edge.
- overflow stays set until rst_n. There is no other clear.
- Simultaneous events: an accepted write and an rptr_sync advance in the same cycle give a net level change of +1-1 = 0. full uses the updated values of both.
- Flags are pessimistic: a read freed in the other domain frees space here only after rptr_sync advances, a minimum of 2 clk edges later. This is by design.
- Empty is not generated here; it is the read-side block's job.

Decomposition:
- Shared package async_fifo_pkg, holding:
  - function bin2gray(bin) and function gray2bin(gray), parameterized by width through a localparam PTR_W = ADDR_WIDTH+1, or written as generic loops;
  - a DEPTH localparam helper.
- The read-side pointer/empty block reuses the same package.
- No sub-module. Gray conversion is functional logic from the package; synchronization stays in the existing pointer synchronizer instantiated at top level.

Test Plan:
- Reset: hold rst_n=0 with wr_en=1, then release with wr_en=0 -> wptr=0, waddr=0, full=0, wr_level=0, overflow=0. Assert rst_n=0 asynchronously between edges -> outputs clear immediately.
- Fill, with rptr_sync=0: 16 consecutive wr_en cycles ->
  - waddr steps 0..15, wptr follows gray 0,1,3,2,6,...;
  - almost_full rises after the 14th write;
  - full rises after the 16th write, with wr_level=16 and wptr=5'b11000.
- Overflow: from full, wr_en=1 for 1 cycle -> wr_accept=0, wptr unchanged, overflow=1 next edge, and overflow stays 1 after full clears.
- Drain response: while full, step rptr_sync gray 0->1 -> full=0 and wr_level=15 one edge later. One more write -> full=1 again.
- Wrap: drive rptr_sync to track the write pointer minus 2 while writing 40 times -> wbin wraps 31->0, wptr 5'b10000->5'b00000, full never asserts, wr_level stays 2.
- Simultaneous: at wr_level=8, write while rptr_sync advances one step -> wr_level stays 8, almost_full stays 0.
